// File: rtl/if_id_decode_stage_if.sv
// Fetch/decode handshake bundle: fetch-side inputs plus the held, decoded instruction fields.
// The master modport is the fetch/downstream environment; the slave modport is the stage.
interface if_id_decode_stage_if;
    logic        InValid;
    logic        InReady;
    logic [15:0] InInstr;
    logic        Flush;
    logic        OutReady;
    logic        OutValid;
    logic [3:0]  Opcode;
    logic [3:0]  Rs;
    logic [3:0]  Rt;
    logic [3:0]  Rd;
    logic        RegDstSel;
    logic        RegWrite;
    logic        MemRead;
    logic        Bubble;

    modport master (
        output InValid, InInstr, Flush, OutReady,
        input  InReady, OutValid, Opcode, Rs, Rt, Rd, RegDstSel, RegWrite, MemRead, Bubble
    );

    modport slave (
        input  InValid, InInstr, Flush, OutReady,
        output InReady, OutValid, Opcode, Rs, Rt, Rd, RegDstSel, RegWrite, MemRead, Bubble
    );
endinterface

// File: rtl/if_id_decode_stage.sv
// One-entry IF/ID pipeline register with field split, control decode and a single-bubble
// load-use hazard stall.
module if_id_decode_stage #(
    parameter int unsigned INSTR_W  = 16,
    parameter logic [15:0] NOP_WORD = 16'hF000
) (
    input logic                  Clk,
    input logic                  Reset,
    if_id_decode_stage_if.slave  bus
);

    logic [INSTR_W-1:0] held_q, held_d;
    logic               valid_q, valid_d;
    logic               bubble_q, bubble_d;

    logic       held_is_lw;
    logic       in_reads_rt;
    logic       hazard;
    logic       accept;
    logic [3:0] in_op;

    assign in_op      = bus.InInstr[15:12];
    assign held_is_lw = valid_q && (held_q[15:12] == 4'h5);

    // Incoming opcodes that consume rt as a source (R-type, SW data, BEQ compare).
    assign in_reads_rt = (in_op <= 4'h3) || (in_op == 4'h6) || (in_op == 4'h7);

    // No R0 exemption: a match on register 0 still stalls.
    assign hazard = held_is_lw && bus.OutReady && bus.InValid &&
                    ((bus.InInstr[11:8] == held_q[7:4]) ||
                     ((bus.InInstr[7:4] == held_q[7:4]) && in_reads_rt));

    assign bus.InReady = (~valid_q | bus.OutReady) & ~hazard;
    assign accept      = bus.InValid & bus.InReady;

    always_comb begin
        held_d   = held_q;
        valid_d  = valid_q;
        bubble_d = 1'b0;
        if (bus.Flush) begin
            held_d  = NOP_WORD;
            valid_d = 1'b0;
        end else if (hazard) begin
            held_d   = NOP_WORD;
            valid_d  = 1'b1;
            bubble_d = 1'b1;
        end else if (accept) begin
            held_d  = bus.InInstr;
            valid_d = 1'b1;
        end else if (valid_q && bus.OutReady) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            held_q   <= NOP_WORD;
            valid_q  <= 1'b0;
            bubble_q <= 1'b0;
        end else begin
            held_q   <= held_d;
            valid_q  <= valid_d;
            bubble_q <= bubble_d;
        end
    end

    assign bus.OutValid = valid_q;
    assign bus.Bubble   = bubble_q;
    assign bus.Opcode   = held_q[15:12];
    assign bus.Rs       = held_q[11:8];
    assign bus.Rt       = held_q[7:4];
    assign bus.Rd       = held_q[3:0];

    // Control comes only from the held word, never from InInstr.
    always_comb begin
        bus.RegDstSel = 1'b0;
        bus.RegWrite  = 1'b0;
        bus.MemRead   = 1'b0;
        case (held_q[15:12])
            4'h0, 4'h1, 4'h2, 4'h3: begin
                bus.RegDstSel = 1'b1;
                bus.RegWrite  = 1'b1;
            end
            4'h4: bus.RegWrite = 1'b1;
            4'h5: begin
                bus.RegWrite = 1'b1;
                bus.MemRead  = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_if_id_decode_stage.sv
// Directed bench for if_id_decode_stage: reset, streaming, backpressure, load-use bubbles,
// flush and reset during a stall, each with hand-computed expected output vectors.
module tb_if_id_decode_stage;

    logic Clk;
    logic Reset;
    int   tests_run;
    int   tests_failed;
    logic [21:0] exp_v;

    if_id_decode_stage_if bus ();

    if_id_decode_stage dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Observation order: {OutValid, Bubble, InReady, Opcode, Rs, Rt, Rd, RegDstSel, RegWrite, MemRead}
    function automatic logic [21:0] snap();
        return {bus.OutValid, bus.Bubble, bus.InReady, bus.Opcode, bus.Rs, bus.Rt, bus.Rd,
                bus.RegDstSel, bus.RegWrite, bus.MemRead};
    endfunction

    task automatic cycle();
        @(posedge Clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [15:0] instr, input logic fl,
                         input logic ordy);
        bus.InValid  = v;
        bus.InInstr  = instr;
        bus.Flush    = fl;
        bus.OutReady = ordy;
        #1;
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        drive(1'b0, 16'h0000, 1'b0, 1'b0);
        repeat (2) @(posedge Clk);
        #1;
        Reset = 1'b0;
        #1;
        exp_v = {1'b0, 1'b0, 1'b1, 16'hF000, 1'b0, 1'b0, 1'b0};
        tests_run++;
        if (snap() !== exp_v) begin
            tests_failed++;
            $display("FAIL reset: got %h expected %h", snap(), exp_v);
        end
        cycle();
        tests_run++;
        if (snap() !== exp_v) begin
            tests_failed++;
            $display("FAIL reset_idle: got %h expected %h", snap(), exp_v);
        end
    endtask

    task automatic test_stream();
        drive(1'b1, 16'h0123, 1'b0, 1'b1);
        cycle();
        drive(1'b1, 16'h4567, 1'b0, 1'b1);
        exp_v = {1'b1, 1'b0, 1'b1, 16'h0123, 1'b1, 1'b1, 1'b0};
        tests_run++;
        if (snap() !== exp_v) begin
            tests_failed++;
            $display("FAIL stream_add: got %h expected %h", snap(), exp_v);
        end
        cycle();
        drive(1'b0, 16'h0000, 1'b0, 1'b1);
        exp_v = {1'b1, 1'b0, 1'b1, 16'h4567, 1'b0, 1'b1, 1'b0};
        tests_run++;
        if (snap() !== exp_v) begin
            tests_failed++;
            $display("FAIL stream_addi: got %h expected %h", snap(), exp_v);
        end
        cycle();
        tests_run++;
        if ({bus.OutValid, bus.InReady} !== 2'b01) begin
            tests_failed++;
            $display("FAIL stream_drain: got %b expected 01", {bus.OutValid, bus.InReady});
        end
    endtask

    task automatic test_backpressure();
        drive(1'b1, 16'h0ABC, 1'b0, 1'b0);
        cycle();
        drive(1'b1, 16'h1111, 1'b0, 1'b0);
        exp_v = {1'b1, 1'b0, 1'b0, 16'h0ABC, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 3; i++) begin
            tests_run++;
            if (snap() !== exp_v) begin
                tests_failed++;
                $display("FAIL hold_%0d: got %h expected %h", i, snap(), exp_v);
            end
            cycle();
        end
        drive(1'b1, 16'h1111, 1'b0, 1'b1);
        exp_v = {1'b1, 1'b0, 1'b1, 16'h0ABC, 1'b1, 1'b1, 1'b0};
        tests_run++;
        if (snap() !== exp_v) begin
            tests_failed++;
            $display("FAIL release: got %h expected %h", snap(), exp_v);
        end
        cycle();
        drive(1'b0, 16'h0000, 1'b0, 1'b1);
        exp_v = {1'b1, 1'b0, 1'b1, 16'h1111, 1'b1, 1'b1, 1'b0};
        tests_run++;
        if (snap() !== exp_v) begin
            tests_failed++;
            $display("FAIL after_release: got %h expected %h", snap(), exp_v);
        end
        cycle();
    endtask

    task automatic test_hazard();
        // rs match against LW rt
        drive(1'b1, 16'h5120, 1'b0, 1'b1);
        cycle();
        drive(1'b1, 16'h0234, 1'b0, 1'b1);
        exp_v = {1'b1, 1'b0, 1'b0, 16'h5120, 1'b0, 1'b1, 1'b1};
        tests_run++;
        if (snap() !== exp_v) begin
            tests_failed++;
            $display("FAIL lw_hazard_detect: got %h expected %h", snap(), exp_v);
        end
        cycle();
        exp_v = {1'b1, 1'b1, 1'b1, 16'hF000, 1'b0, 1'b0, 1'b0};
        tests_run++;
        if (snap() !== exp_v) begin
            tests_failed++;
            $display("FAIL bubble_nop: got %h expected %h", snap(), exp_v);
        end
        cycle();
        drive(1'b0, 16'h0000, 1'b0, 1'b1);
        exp_v = {1'b1, 1'b0, 1'b1, 16'h0234, 1'b1, 1'b1, 1'b0};
        tests_run++;
        if (snap() !== exp_v) begin
            tests_failed++;
            $display("FAIL stalled_add: got %h expected %h", snap(), exp_v);
        end
        cycle();

        // no register overlap
        drive(1'b1, 16'h5120, 1'b0, 1'b1);
        cycle();
        drive(1'b1, 16'h0345, 1'b0, 1'b1);
        exp_v = {1'b1, 1'b0, 1'b1, 16'h5120, 1'b0, 1'b1, 1'b1};
        tests_run++;
        if (snap() !== exp_v) begin
            tests_failed++;
            $display("FAIL lw_no_hazard: got %h expected %h", snap(), exp_v);
        end
        cycle();
        drive(1'b0, 16'h0000, 1'b0, 1'b1);
        exp_v = {1'b1, 1'b0, 1'b1, 16'h0345, 1'b1, 1'b1, 1'b0};
        tests_run++;
        if (snap() !== exp_v) begin
            tests_failed++;
            $display("FAIL add_no_bubble: got %h expected %h", snap(), exp_v);
        end
        cycle();

        // rt match through SW (reads rt)
        drive(1'b1, 16'h5120, 1'b0, 1'b1);
        cycle();
        drive(1'b1, 16'h6320, 1'b0, 1'b1);
        exp_v = {1'b1, 1'b0, 1'b0, 16'h5120, 1'b0, 1'b1, 1'b1};
        tests_run++;
        if (snap() !== exp_v) begin
            tests_failed++;
            $display("FAIL sw_rt_hazard: got %h expected %h", snap(), exp_v);
        end
        cycle();
        exp_v = {1'b1, 1'b1, 1'b1, 16'hF000, 1'b0, 1'b0, 1'b0};
        tests_run++;
        if (snap() !== exp_v) begin
            tests_failed++;
            $display("FAIL sw_bubble: got %h expected %h", snap(), exp_v);
        end
        cycle();
        drive(1'b0, 16'h0000, 1'b0, 1'b1);
        exp_v = {1'b1, 1'b0, 1'b1, 16'h6320, 1'b0, 1'b0, 1'b0};
        tests_run++;
        if (snap() !== exp_v) begin
            tests_failed++;
            $display("FAIL sw_accept: got %h expected %h", snap(), exp_v);
        end
        cycle();

        // rt match through ADDI (rt is its destination) must not stall
        drive(1'b1, 16'h5120, 1'b0, 1'b1);
        cycle();
        drive(1'b1, 16'h4320, 1'b0, 1'b1);
        exp_v = {1'b1, 1'b0, 1'b1, 16'h5120, 1'b0, 1'b1, 1'b1};
        tests_run++;
        if (snap() !== exp_v) begin
            tests_failed++;
            $display("FAIL addi_rt_no_hazard: got %h expected %h", snap(), exp_v);
        end
        cycle();
        drive(1'b0, 16'h0000, 1'b0, 1'b1);
        exp_v = {1'b1, 1'b0, 1'b1, 16'h4320, 1'b0, 1'b1, 1'b0};
        tests_run++;
        if (snap() !== exp_v) begin
            tests_failed++;
            $display("FAIL addi_accept: got %h expected %h", snap(), exp_v);
        end
        cycle();

        // register 0 still stalls
        drive(1'b1, 16'h5100, 1'b0, 1'b1);
        cycle();
        drive(1'b1, 16'h0011, 1'b0, 1'b1);
        exp_v = {1'b1, 1'b0, 1'b0, 16'h5100, 1'b0, 1'b1, 1'b1};
        tests_run++;
        if (snap() !== exp_v) begin
            tests_failed++;
            $display("FAIL r0_hazard: got %h expected %h", snap(), exp_v);
        end
        cycle();
        cycle();
        drive(1'b0, 16'h0000, 1'b0, 1'b1);
        exp_v = {1'b1, 1'b0, 1'b1, 16'h0011, 1'b1, 1'b1, 1'b0};
        tests_run++;
        if (snap() !== exp_v) begin
            tests_failed++;
            $display("FAIL r0_accept: got %h expected %h", snap(), exp_v);
        end
        cycle();
    endtask

    task automatic test_flush();
        drive(1'b1, 16'h3456, 1'b0, 1'b0);
        cycle();
        drive(1'b1, 16'h2222, 1'b1, 1'b0);
        cycle();
        drive(1'b0, 16'h0000, 1'b0, 1'b1);
        exp_v = {1'b0, 1'b0, 1'b1, 16'hF000, 1'b0, 1'b0, 1'b0};
        tests_run++;
        if (snap() !== exp_v) begin
            tests_failed++;
            $display("FAIL flush: got %h expected %h", snap(), exp_v);
        end
        cycle();
        tests_run++;
        if (snap() !== exp_v) begin
            tests_failed++;
            $display("FAIL flush_no_leak: got %h expected %h", snap(), exp_v);
        end

        drive(1'b1, 16'h5120, 1'b0, 1'b1);
        cycle();
        drive(1'b1, 16'h0234, 1'b1, 1'b1);
        cycle();
        drive(1'b0, 16'h0000, 1'b0, 1'b1);
        tests_run++;
        if (snap() !== exp_v) begin
            tests_failed++;
            $display("FAIL flush_cancels_bubble: got %h expected %h", snap(), exp_v);
        end
        cycle();
        tests_run++;
        if (snap() !== exp_v) begin
            tests_failed++;
            $display("FAIL flush_pending_lost: got %h expected %h", snap(), exp_v);
        end
    endtask

    task automatic test_reset_in_bubble();
        drive(1'b1, 16'h5120, 1'b0, 1'b1);
        cycle();
        drive(1'b1, 16'h0234, 1'b0, 1'b1);
        Reset = 1'b1;
        cycle();
        Reset = 1'b0;
        drive(1'b0, 16'h0000, 1'b0, 1'b1);
        exp_v = {1'b0, 1'b0, 1'b1, 16'hF000, 1'b0, 1'b0, 1'b0};
        tests_run++;
        if (snap() !== exp_v) begin
            tests_failed++;
            $display("FAIL reset_in_bubble: got %h expected %h", snap(), exp_v);
        end
        cycle();
        tests_run++;
        if (snap() !== exp_v) begin
            tests_failed++;
            $display("FAIL reset_stalled_lost: got %h expected %h", snap(), exp_v);
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        Reset        = 1'b1;
        bus.InValid  = 1'b0;
        bus.InInstr  = 16'h0000;
        bus.Flush    = 1'b0;
        bus.OutReady = 1'b0;
        test_reset();
        test_stream();
        test_backpressure();
        test_hazard();
        test_flush();
        test_reset_in_bubble();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
